// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the multi-cycle phase sequencer: state codes, phase
// indices used by the register/ALU control blocks, and decode helpers.
package phase_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_P1     = 3'd1,
        ST_P2     = 3'd2,
        ST_P3     = 3'd3,
        ST_P4     = 3'd4,
        ST_P5     = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    localparam int NUM_PHASES      = 5;
    localparam int PHASE_FETCH     = 0;
    localparam int PHASE_DECODE    = 1;
    localparam int PHASE_EXECUTE   = 2;
    localparam int PHASE_MEMORY    = 3;
    localparam int PHASE_WRITEBACK = 4;

    // One-hot phase enable vector for a state; IDLE/HALTED give all zeros.
    function automatic logic [NUM_PHASES-1:0] phase_onehot(input state_t s);
        logic [NUM_PHASES-1:0] v;
        v = '0;
        case (s)
            ST_P1:   v[PHASE_FETCH]     = 1'b1;
            ST_P2:   v[PHASE_DECODE]    = 1'b1;
            ST_P3:   v[PHASE_EXECUTE]   = 1'b1;
            ST_P4:   v[PHASE_MEMORY]    = 1'b1;
            ST_P5:   v[PHASE_WRITEBACK] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic is_running(input state_t s);
        return (s inside {ST_P1, ST_P2, ST_P3, ST_P4, ST_P5});
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the sequencer and the datapath decode logic.
// The master side is the sequencer itself; the slave side is whoever drives its inputs.
interface phase_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 halt_req;
    logic                 skip_mem;
    logic                 mem_wait;
    logic                 p1;
    logic                 p2;
    logic                 p3;
    logic                 p4;
    logic                 p5;
    logic                 running;
    logic                 halted;
    logic                 bus_error;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  start, halt_req, skip_mem, mem_wait,
        output p1, p2, p3, p4, p5, running, halted, bus_error, retired
    );

    modport slave (
        output start, halt_req, skip_mem, mem_wait,
        input  p1, p2, p3, p4, p5, running, halted, bus_error, retired
    );

endinterface

// File: rtl/phase_sequencer_mem_wait_timer.sv
// Counts consecutive memory-wait stall cycles and flags a timeout on the stall
// that arrives after WAIT_LIMIT stalls have already been absorbed.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] count;

    assign timeout = inc && (count == CW'(WAIT_LIMIT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || timeout) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle control sequencer: walks fetch/decode/execute/memory/write-back
// phases, handles start/halt, memory stalls with timeout, and retires instructions.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int WAIT_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    phase_sequencer_if.master   bus
);

    state_t                 state_q;
    state_t                 state_d;
    logic [NUM_PHASES-1:0]  phase_q;
    logic                   running_q;
    logic                   halted_q;
    logic                   bus_error_q;
    logic [CNT_WIDTH-1:0]   retired_q;
    logic                   stall;
    logic                   timeout;

    assign stall = (state_q == ST_P4) && bus.mem_wait;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (!stall),
        .inc     (stall),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_P1;
            ST_P1:     state_d = ST_P2;
            ST_P2:     state_d = ST_P3;
            ST_P3:     state_d = bus.skip_mem ? ST_P5 : ST_P4;
            ST_P4: begin
                if (!bus.mem_wait) begin
                    state_d = ST_P5;
                end else if (timeout) begin
                    state_d = ST_HALTED;
                end
            end
            ST_P5:     state_d = bus.halt_req ? ST_HALTED : ST_P1;
            ST_HALTED: if (bus.start) state_d = ST_P1;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_onehot(state_d);
            running_q <= is_running(state_d);
            halted_q  <= (state_d == ST_HALTED);
            if (timeout) begin
                bus_error_q <= 1'b1;
            end else if ((state_q == ST_HALTED) && bus.start) begin
                bus_error_q <= 1'b0;
            end
            if (state_q == ST_P5) begin
                retired_q <= retired_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.p1        = phase_q[PHASE_FETCH];
    assign bus.p2        = phase_q[PHASE_DECODE];
    assign bus.p3        = phase_q[PHASE_EXECUTE];
    assign bus.p4        = phase_q[PHASE_MEMORY];
    assign bus.p5        = phase_q[PHASE_WRITEBACK];
    assign bus.running   = running_q;
    assign bus.halted    = halted_q;
    assign bus.bus_error = bus_error_q;
    assign bus.retired   = retired_q;

endmodule
